// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one FP32 multiplier driver among N_REQ requesters.
// One operation in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module fp_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*32-1:0]   req_a,
  input  logic [N_REQ*32-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_z,
  output logic                  rsp_timeout,
  output logic                  mul_start,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic                  mul_busy,
  input  logic                  mul_done,
  input  logic [31:0]           mul_z,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state;
  logic [GW-1:0]      gid;
  logic [GW-1:0]      search_start;
  logic [CW-1:0]      cnt;

  logic [2*N_REQ-1:0] rv_dbl;
  logic [N_REQ-1:0]   rv_rot;
  logic [GW-1:0]      pick_off;
  logic [GW:0]        pick_sum;
  logic [GW-1:0]      pick_id;
  logic               pick_found;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;

  // Rotate the request vector so bit 0 is the first candidate, then take the lowest set bit.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rv_dbl     = {req_valid, req_valid};
    rv_rot     = rv_dbl[N_REQ-1:0];
    rv_rot     = N_REQ'(rv_dbl >> search_start);
    pick_off   = '0;
    pick_found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rv_rot[k]) begin
        pick_off   = GW'(k);
        pick_found = 1'b1;
      end
    end
    pick_sum = {1'b0, search_start} + {1'b0, pick_off};
    if (pick_sum >= (GW+1)'(N_REQ)) begin
      pick_id = GW'(pick_sum - (GW+1)'(N_REQ));
    end else begin
      pick_id = pick_sum[GW-1:0];
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_id == GW'(k)) begin
        sel_a = req_a[k*32 +: 32];
        sel_b = req_b[k*32 +: 32];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      gid          <= '0;
      search_start <= '0;
      cnt          <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      mul_start    <= 1'b0;
      busy         <= 1'b0;
      rsp_timeout  <= 1'b0;
      err_timeout  <= 1'b0;
      rsp_z        <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
    end else begin
      // Handshake outputs are single-cycle pulses unless a state below raises them.
      req_ready <= '0;
      rsp_valid <= '0;
      mul_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found && !mul_busy) begin
            gid       <= pick_id;
            mul_a     <= sel_a;
            mul_b     <= sel_b;
            req_ready <= N_REQ'(1) << pick_id;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done && !mul_busy) begin
            rsp_z       <= mul_z;
            rsp_timeout <= 1'b0;
            rsp_valid   <= N_REQ'(1) << gid;
            state       <= S_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_z       <= QNAN;
            rsp_timeout <= 1'b1;
            err_timeout <= 1'b1;
            rsp_valid   <= N_REQ'(1) << gid;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          search_start <= (gid == GW'(N_REQ - 1)) ? '0 : gid + GW'(1);
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: directed scenarios followed by random traffic,
// with a mock multiplier driver and a round-robin reference model in the monitor.
module tb_fp_mul_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_z;
  logic            rsp_timeout;
  logic            mul_start;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic            mul_busy = 1'b0;
  logic            mul_done = 1'b0;
  logic [31:0]     mul_z = '0;
  logic            busy;
  logic            err_timeout;

  typedef struct packed {
    logic [31:0] z;
    logic        to;
  } exp_t;

  exp_t exp_q [N][$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   stim_done = 1'b0;
  bit   stim_hung = 1'b0;

  int   lat = 5;
  bit   hang = 1'b0;
  int   hang_len = 90;
  bit   force_busy = 1'b0;
  int   mock_rem = 0;

  fp_mul_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_timeout(rsp_timeout),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_z(mul_z),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mock_mul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000) return b;
    return a ^ {b[7:0], b[31:8]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] pend, input int start);
    for (int k = 0; k < N; k++) begin
      if (pend[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mock multiplier driver: accepts a start, stays busy for lat cycles, then raises a done level.
  initial begin : mock
    logic        st;
    logic [31:0] la, lb;
    bit          ibusy, ihang;
    ibusy = 1'b0; ihang = 1'b0; la = '0; lb = '0;
    forever begin
      @(negedge clk);
      st = mul_start;
      if (st) begin la = mul_a; lb = mul_b; end
      @(posedge clk); #1;
      if (st) begin
        mul_done = 1'b0;
        ibusy    = 1'b1;
        ihang    = hang;
        mock_rem = hang ? hang_len : lat;
      end else if (mock_rem > 0) begin
        mock_rem--;
        if (mock_rem == 0) begin
          ibusy = 1'b0;
          if (!ihang) begin
            mul_done = 1'b1;
            mul_z    = mock_mul(la, lb);
          end
        end
      end
      mul_busy = ibusy | force_busy;
    end
  end

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_ready;
    @(posedge clk); #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_valid[id] = 1'b1;
    e.z  = hang ? 32'h7FC0_0000 : mock_mul(a, b);
    e.to = hang;
    exp_q[id].push_back(e);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(req_valid == '0 && !busy && mock_rem == 0)) begin
      if (n >= limit) begin
        stim_hung = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin : stim
    repeat (3) tick();
    rst = 1'b0;
    tick();

    lat = 5;
    issue(1, 32'h3F80_0000, 32'h4000_0000);
    wait_idle(200);

    do_reset();
    lat = 3;
    issue(0, $urandom, $urandom);
    issue(2, $urandom, $urandom);
    wait_idle(200);

    do_reset();
    lat = 2;
    begin : fairness
      int  cnt_i [N];
      bit  all_done;
      foreach (cnt_i[i]) cnt_i[i] = 0;
      for (int t = 0; t < 400; t++) begin
        all_done = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] && cnt_i[i] < 2) begin
            issue(i, $urandom, $urandom);
            cnt_i[i]++;
          end
          if (cnt_i[i] < 2) all_done = 1'b0;
        end
        if (all_done) break;
        tick();
      end
      wait_idle(200);
    end

    hang = 1'b1;
    hang_len = 90;
    issue(3, $urandom, $urandom);
    repeat (70) tick();
    hang = 1'b0;
    lat = 4;
    issue(0, 32'h3F80_0000, $urandom);
    wait_idle(300);

    force_busy = 1'b1;
    tick();
    issue(3, $urandom, $urandom);
    repeat (10) tick();
    force_busy = 1'b0;
    wait_idle(100);

    lat = 2;
    issue(2, $urandom, $urandom);
    wait_idle(100);
    lat = 20;
    issue(1, $urandom, $urandom);
    repeat (8) tick();
    do_reset();
    lat = 2;
    issue(3, $urandom, $urandom);
    issue(0, $urandom, $urandom);
    wait_idle(200);

    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(3) == 0) begin
          lat = $urandom_range(6, 1);
          issue(i, ($urandom_range(3) == 0) ? 32'h3F80_0000 : $urandom, $urandom);
        end else if (req_valid[i] && !req_ready[i] && $urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
          void'(exp_q[i].pop_back());
        end
      end
      tick();
    end
    wait_idle(500);
    repeat (3) tick();
    stim_done = 1'b1;
  end

  // Monitor: predicts grant timing/owner from the round-robin rules and pops the scoreboard on responses.
  initial begin : monitor
    int          cyc, ptr, cur, issue_cyc, due_cyc, pred;
    bit          rst_prev, grant_due, active, resolved, due_to, rsp_now;
    logic [N-1:0] last_rv;
    logic        exp_err;
    logic [31:0] exp_rz, exp_ma, exp_mb;
    exp_t        e;
    cyc = 0; ptr = 0; cur = 0; issue_cyc = 0; due_cyc = 0; pred = 0;
    rst_prev = 1'b0; grant_due = 1'b0; active = 1'b0; resolved = 1'b0; due_to = 1'b0;
    last_rv = '0; exp_err = 1'b0; exp_rz = '0; exp_ma = '0; exp_mb = '0;
    while (!stim_done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (rst_prev) begin
        check("reset_outputs",
              {req_ready, rsp_valid, mul_start, busy, rsp_timeout, err_timeout, rsp_z, mul_a, mul_b}, '0);
        ptr = 0; active = 1'b0; resolved = 1'b0;
        exp_err = 1'b0; exp_rz = '0; exp_ma = '0; exp_mb = '0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        grant_due = !rst && (req_valid != '0) && !mul_busy;
      end else begin
        check("grant_timing", req_ready != '0, grant_due);
        check("start_with_ready", mul_start, req_ready != '0);
        if (req_ready != '0) begin
          pred = rr_pick(last_rv, ptr);
          check("grant_id", req_ready, (pred < 0) ? '0 : onehot(pred));
          if (pred >= 0) begin
            exp_ma = req_a[pred*32 +: 32];
            exp_mb = req_b[pred*32 +: 32];
            cur = pred;
          end
          active = 1'b1;
          issue_cyc = cyc;
          resolved = 1'b0;
        end
        check("mul_a", mul_a, exp_ma);
        check("mul_b", mul_b, exp_mb);
        rsp_now = active && resolved && (cyc == due_cyc);
        check("rsp_timing", rsp_valid != '0, rsp_now);
        if (rsp_now && rsp_valid != '0) begin
          check("rsp_owner", rsp_valid, onehot(cur));
          check("rsp_timeout_when", rsp_timeout, due_to);
          check("rsp_queue_nonempty", exp_q[cur].size() != 0, 1'b1);
          if (exp_q[cur].size() != 0) begin
            e = exp_q[cur].pop_front();
            check("rsp_z", rsp_z, e.z);
            check("rsp_timeout_sb", rsp_timeout, e.to);
            exp_rz = e.z;
          end
          if (due_to) exp_err = 1'b1;
          ptr = (cur + 1) % N;
        end
        check("busy", busy, active);
        check("err_timeout", err_timeout, exp_err);
        check("rsp_z_hold", rsp_z, exp_rz);
        grant_due = !active && !rst && (req_valid != '0) && !mul_busy;
        if (rsp_now) active = 1'b0;
        if (active && !resolved && cyc > issue_cyc) begin
          if (mul_done && !mul_busy) begin
            due_cyc = cyc + 1; due_to = 1'b0; resolved = 1'b1;
          end else if (cyc - issue_cyc - 1 == TO - 1) begin
            due_cyc = cyc + 1; due_to = 1'b1; resolved = 1'b1;
          end
        end
      end
      rst_prev = rst;
      last_rv = req_valid;
    end
    check("cycle_budget", cyc < 40000, 1'b1);
    check("stimulus_bounded", stim_hung, 1'b0);
    for (int i = 0; i < N; i++) check("queue_drained", exp_q[i].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
